// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared_reg_arbiter block.
//   state_t : sequencer states (IDLE -> GRANT -> HOLD -> IDLE)
//   idx_w   : width of an index into n items, never less than 1 bit
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // A single requester (or a one-cycle hold) still needs a 1-bit field.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
// Scans requesters in the order ptr, ptr+1, ... wrapping modulo N and
// reports the first one that is requesting.
// Ports:
//   i_req        : per-requester request bits
//   i_ptr        : index where the search starts (must be < N)
//   o_gnt_next   : one-hot winner, all zero when nobody requests
//   o_idx_next   : binary index of the winner, 0 when nobody requests
//   o_any        : at least one request is present
module shared_reg_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_next,
  output logic [IW-1:0] o_idx_next,
  output logic          o_any
);

  // Walk the rotated order once; the first hit locks the result so later
  // (lower-priority) requesters cannot overwrite it.
  always_comb begin
    int unsigned j;
    j          = 0;
    o_gnt_next = '0;
    o_idx_next = '0;
    o_any      = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[j]) begin
        o_any         = 1'b1;
        o_idx_next    = IW'(j);
        o_gnt_next[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin sequencer that shares one W-bit holding register among N
// requesters. A winner is granted for one cycle, its data lane is loaded
// into the register, and the value is then held (owned) for HOLD cycles
// before the next arbitration.
// Ports:
//   i_clk      : rising-edge clock
//   i_reset    : synchronous active-high reset
//   i_req      : per-requester request; bit i = requester i
//   i_wr_data  : flattened write data; requester i at [i*W +: W]
//   o_gnt      : one-hot grant pulse, high for the single GRANT cycle
//   o_q        : shared register contents
//   o_q_valid  : o_q holds data loaded since the last reset
//   o_owner    : index of the most recently granted requester
//   o_busy     : sequencer is in GRANT or HOLD
module shared_reg_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 2
) (
  input  logic                                         i_clk,
  input  logic                                         i_reset,
  input  logic [N-1:0]                                 i_req,
  input  logic [N*W-1:0]                               i_wr_data,
  output logic [N-1:0]                                 o_gnt,
  output logic [W-1:0]                                 o_q,
  output logic                                         o_q_valid,
  output logic [shared_reg_arbiter_pkg::idx_w(N)-1:0]  o_owner,
  output logic                                         o_busy
);

  import shared_reg_arbiter_pkg::*;

  localparam int IW = idx_w(N);
  localparam int CW = idx_w(HOLD);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  // The HOLD parameter shadows the package enum literal of the same name,
  // so the state is always referenced through the package scope.
  localparam state_t ST_HOLD = shared_reg_arbiter_pkg::HOLD;

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_gnt;
  logic [W-1:0]  r_q;
  logic          r_q_valid;
  logic [IW-1:0] r_owner;
  logic          r_busy;

  logic [N-1:0]  w_gnt_next;
  logic [IW-1:0] w_idx_next;
  logic          w_any;
  logic [W-1:0]  w_lane;

  shared_reg_arbiter_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_req      (i_req),
    .i_ptr      (r_ptr),
    .o_gnt_next (w_gnt_next),
    .o_idx_next (w_idx_next),
    .o_any      (w_any)
  );

  // Data is taken from the owner's lane regardless of whether it still
  // requests; requesters are expected to hold data until they see gnt.
  assign w_lane = i_wr_data[int'(r_owner) * W +: W];

  // Single sequencer: arbitrate in IDLE, load in GRANT, freeze in HOLD.
  // Every output is a register so nothing combinational reaches gnt.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt_next;
            r_owner <= w_idx_next;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end else begin
            r_gnt   <= '0;
          end
        end
        GRANT: begin
          r_gnt     <= '0;
          r_q       <= w_lane;
          r_q_valid <= 1'b1;
          // Explicit wrap keeps the pointer in range for non-power-of-2 N.
          r_ptr     <= (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
          r_cnt     <= HOLD_LOAD;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_q       = r_q;
  assign o_q_valid = r_q_valid;
  assign o_owner   = r_owner;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter (N=4, W=8, HOLD=2).
// A table of per-cycle vectors covers reset, a single request and the
// fairness rotation; short hand-written sequences cover wrap-around,
// requests during HOLD and reset in the middle of a grant; a randomized
// phase is compared against a transaction-level reference model.
module tb_shared_reg_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wrData;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           qValid;
  logic [1:0]     owner;
  logic           busy;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        valid;
    logic [1:0]  owner;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: mLeft counts the cycles still owed to the
  // current transaction (GRANT + HOLD), zero meaning the arbiter is idle.
  int         mLeft, mPtr, mOwner;
  logic [7:0] mQ;
  logic       mValid, mBusy;
  logic [3:0] mGnt;

  shared_reg_arbiter #(
    .N    (N),
    .W    (W),
    .HOLD (HOLD)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_req     (req),
    .i_wr_data (wrData),
    .o_gnt     (gnt),
    .o_q       (q),
    .o_q_valid (qValid),
    .o_owner   (owner),
    .o_busy    (busy)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, settle 1 ns after it.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [31:0] d);
    reset  = r;
    req    = rq;
    wrData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eGnt, input logic [7:0] eQ,
                             input logic eValid, input logic [1:0] eOwner, input logic eBusy);
    checkCount++;
    if ({gnt, q, qValid, owner, busy} !== {eGnt, eQ, eValid, eOwner, eBusy}) begin
      $display("[TB] FAIL %s: got gnt=%b q=%h valid=%b owner=%0d busy=%b, expected gnt=%b q=%h valid=%b owner=%0d busy=%b",
               name, gnt, q, qValid, owner, busy, eGnt, eQ, eValid, eOwner, eBusy);
    end else begin
      passCount++;
    end
  endtask

  function automatic void addVec(input logic r, input logic [3:0] rq, input logic [31:0] d,
                                 input logic [3:0] g, input logic [7:0] qq, input logic v,
                                 input logic [1:0] o, input logic b);
    vec_t t;
    t.rst = r; t.req = rq; t.data = d; t.gnt = g; t.q = qq;
    t.valid = v; t.owner = o; t.busy = b;
    vecs.push_back(t);
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic modelStep(input logic rst, input logic [3:0] rq, input logic [31:0] d);
    int w;
    if (rst) begin
      mLeft = 0; mPtr = 0; mOwner = 0; mQ = '0;
      mValid = 1'b0; mBusy = 1'b0; mGnt = '0;
    end else if (mLeft == 0) begin
      mGnt = '0;
      if (rq != 0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && rq[(mPtr + k) % N]) w = (mPtr + k) % N;
        mOwner = w;
        mGnt   = 4'(1 << w);
        mBusy  = 1'b1;
        mLeft  = HOLD + 1;
      end
    end else begin
      if (mLeft == HOLD + 1) begin
        mQ     = d[mOwner * W +: W];
        mValid = 1'b1;
        mPtr   = (mOwner + 1) % N;
        mGnt   = '0;
      end
      mLeft--;
      if (mLeft == 0) mBusy = 1'b0;
    end
  endtask

  initial begin
    logic        rr;
    logic [3:0]  rq;
    logic [31:0] rd;

    reset  = 1'b1;
    req    = '0;
    wrData = '0;

    // Reset and idle, single request (lane2=A5), then reset and fairness.
    addVec(1, 4'b0000, 32'h0,        4'b0000, 8'h00, 0, 0, 0);
    addVec(1, 4'b0000, 32'h0,        4'b0000, 8'h00, 0, 0, 0);
    addVec(0, 4'b0000, 32'h0,        4'b0000, 8'h00, 0, 0, 0);
    addVec(0, 4'b0000, 32'h0,        4'b0000, 8'h00, 0, 0, 0);
    addVec(0, 4'b0100, 32'h00A50000, 4'b0100, 8'h00, 0, 2, 1);
    addVec(0, 4'b0000, 32'h00A50000, 4'b0000, 8'hA5, 1, 2, 1);
    addVec(0, 4'b0000, 32'h00A50000, 4'b0000, 8'hA5, 1, 2, 1);
    addVec(0, 4'b0000, 32'h00A50000, 4'b0000, 8'hA5, 1, 2, 0);
    addVec(0, 4'b0000, 32'h00A50000, 4'b0000, 8'hA5, 1, 2, 0);
    addVec(1, 4'b0000, 32'h0,        4'b0000, 8'h00, 0, 0, 0);
    addVec(0, 4'b1111, 32'h40302010, 4'b0001, 8'h00, 0, 0, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h10, 1, 0, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h10, 1, 0, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h10, 1, 0, 0);
    addVec(0, 4'b1111, 32'h40302010, 4'b0010, 8'h10, 1, 1, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h20, 1, 1, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h20, 1, 1, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h20, 1, 1, 0);
    addVec(0, 4'b1111, 32'h40302010, 4'b0100, 8'h20, 1, 2, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h30, 1, 2, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h30, 1, 2, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h30, 1, 2, 0);
    addVec(0, 4'b1111, 32'h40302010, 4'b1000, 8'h30, 1, 3, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h40, 1, 3, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h40, 1, 3, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h40, 1, 3, 0);
    addVec(0, 4'b1111, 32'h40302010, 4'b0001, 8'h40, 1, 0, 1);
    addVec(0, 4'b1111, 32'h40302010, 4'b0000, 8'h10, 1, 0, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].valid,
                  vecs[i].owner, vecs[i].busy);
    end

    // Wrap-around: after granting 2 the pointer sits at 3, so 3 beats 0.
    applyStimulus(1, 4'b0000, 32'h0);
    checkOutput("wrap_reset", 4'b0000, 8'h00, 0, 0, 0);
    applyStimulus(0, 4'b0100, 32'h00110000);
    checkOutput("wrap_g2", 4'b0100, 8'h00, 0, 2, 1);
    applyStimulus(0, 4'b0000, 32'h00110000);
    checkOutput("wrap_q2", 4'b0000, 8'h11, 1, 2, 1);
    applyStimulus(0, 4'b0000, 32'h00110000);
    applyStimulus(0, 4'b0000, 32'h00110000);
    checkOutput("wrap_idle", 4'b0000, 8'h11, 1, 2, 0);
    applyStimulus(0, 4'b1001, 32'h330000AA);
    checkOutput("wrap_g3", 4'b1000, 8'h11, 1, 3, 1);
    applyStimulus(0, 4'b0001, 32'h330000AA);
    checkOutput("wrap_q3", 4'b0000, 8'h33, 1, 3, 1);
    applyStimulus(0, 4'b0001, 32'h330000AA);
    applyStimulus(0, 4'b0001, 32'h330000AA);
    applyStimulus(0, 4'b0001, 32'h330000AA);
    checkOutput("wrap_g0", 4'b0001, 8'h33, 1, 0, 1);
    applyStimulus(0, 4'b0000, 32'h330000AA);
    checkOutput("wrap_q0", 4'b0000, 8'hAA, 1, 0, 1);

    // Request from 1 arrives during HOLD of requester 0: no early grant.
    applyStimulus(0, 4'b0010, 32'h330077AA);
    checkOutput("hold_frozen", 4'b0000, 8'hAA, 1, 0, 1);
    applyStimulus(0, 4'b0010, 32'h330077AA);
    checkOutput("hold_to_idle", 4'b0000, 8'hAA, 1, 0, 0);
    applyStimulus(0, 4'b0010, 32'h330077AA);
    checkOutput("hold_late_g1", 4'b0010, 8'hAA, 1, 1, 1);
    applyStimulus(0, 4'b0000, 32'h330077AA);
    checkOutput("hold_late_q1", 4'b0000, 8'h77, 1, 1, 1);
    applyStimulus(0, 4'b0000, 32'h330077AA);
    applyStimulus(0, 4'b0000, 32'h330077AA);
    checkOutput("hold_done", 4'b0000, 8'h77, 1, 1, 0);

    // Reset during GRANT discards the load; pointer returns to 0, so
    // req=1010 must pick 1 rather than 3.
    applyStimulus(0, 4'b0100, 32'h00C30000);
    checkOutput("mid_g2", 4'b0100, 8'h77, 1, 2, 1);
    applyStimulus(1, 4'b0100, 32'h00C30000);
    checkOutput("mid_reset", 4'b0000, 8'h00, 0, 0, 0);
    applyStimulus(0, 4'b1010, 32'h00005A00);
    checkOutput("mid_after_g1", 4'b0010, 8'h00, 0, 1, 1);
    applyStimulus(0, 4'b0000, 32'h00005A00);
    checkOutput("mid_after_q1", 4'b0000, 8'h5A, 1, 1, 1);

    // Randomized traffic against the reference model, starting from reset.
    modelStep(1'b1, 4'b0000, 32'h0);
    applyStimulus(1'b1, 4'b0000, 32'h0);
    checkOutput("rand_reset", mGnt, mQ, mValid, 2'(mOwner), mBusy);
    for (int c = 0; c < 800; c++) begin
      rr = ($urandom_range(0, 59) == 0);
      rq = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      rd = $urandom;
      modelStep(rr, rq, rd);
      applyStimulus(rr, rq, rd);
      checkOutput($sformatf("rand%0d", c), mGnt, mQ, mValid, 2'(mOwner), mBusy);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

- Round-robin arbiter/sequencer that shares one W-bit synchronously-reset data register among N requesters.
- Grants the register to one requester at a time and loads that requester's data.
- Holds the value stable and owned for a fixed window, then releases.
- Sits between multiple FSMD datapath producers and a single shared holding register; its output feeds downstream consumers.

## Interface
- N, 4, number of requesters (1..8)
- W, 8, data width of the shared register
- HOLD, 2, cycles the value is held locked after load (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  N  per-requester request; bit i = requester i
- wr_data  in  N*W  flattened data; requester i at bits [i*W +: W]
- gnt  out  N  one-hot grant pulse, registered
- q  out  W  shared register contents
- q_valid  out  1  q holds data loaded since last reset
- owner  out  clog2(N) (min 1)  index of last granted requester
- busy  out  1  arbiter not in IDLE

## Operation
- States: IDLE, GRANT, HOLD.
- IDLE: if any req bit is high, pick a winner by round-robin starting at ptr. Register gnt (one-hot) and owner. Go to GRANT. Otherwise stay; gnt=0.
- GRANT: gnt is high for exactly this cycle. q <= wr_data[owner] at the end of the cycle; q_valid <= 1. ptr <= (owner+1) mod N. Load hold counter with HOLD-1. Go to HOLD.
- HOLD: q, owner and q_valid are frozen; gnt=0. Decrement the counter; at 0, go to IDLE.
- Requests arriving in GRANT/HOLD are not lost. They are sampled again on return to IDLE.
- Requester contract: keep req and wr_data stable until gnt is seen. Data is captured from owner's lane in GRANT regardless of req; violations are not checked.
- req deassertion in IDLE before selection is simply ignored (no grant).
- Round-robin: search order ptr, ptr+1, … wrapping mod N. The first set bit wins.
- N=1 degenerates to a fixed grant with the same timing.
- Reset values: state=IDLE, gnt=0, q=0, q_valid=0, owner=0, busy=0, ptr=0, counter=0.
- Reset has priority over all transitions, including mid-GRANT/HOLD. A load in progress is discarded, and q returns to 0.

## Timing
- req high in IDLE at cycle t → gnt high at t+1 (GRANT) → q/q_valid updated at t+2.
- busy is high from t+1 through the last HOLD cycle.
- Occupancy per transaction = 1 (GRANT) + HOLD cycles. IDLE lasts at least 1 cycle between transactions.
- Back-to-back: with continuous requests, the grant period is HOLD+2 cycles.
- Each requester waits at most (N-1)·(HOLD+2) cycles after entering contention.
- All outputs are registered; no combinational path from req to gnt.

## Structure
- Shared package shared_reg_arbiter_pkg holds:
  - state enum {IDLE, GRANT, HOLD}
  - idx_w function (max(1, clog2(N)))
- Sub-module rr_pick: combinational N-way rotating priority picker.
  - Inputs: req, ptr.
  - Outputs: one-hot gnt_next, idx_next, any.
  - Instantiated once; the FSM and registers stay in the top.

## Test plan
- Reset then idle: reset=1 for 2 cycles, req=0 → all outputs 0, busy=0 indefinitely.
- Single request: req=4'b0100, lane2=8'hA5 at t → gnt=4'b0100 at t+1 only; q=8'hA5, q_valid=1, owner=2 at t+2; busy falls after 2 HOLD cycles.
- Fairness: req=4'b1111 held, lanes 8'h10/20/30/40 → grant order 0,1,2,3,0. Grants spaced 4 cycles apart (HOLD=2); q follows 10,20,30,40,10.
- Wrap-around: ptr=3 after granting 2, req=4'b1001 → requester 3 first, then 0.
- Request during HOLD: req1 rises in HOLD of a requester-0 transaction → no gnt until IDLE. Grant occurs the cycle after IDLE; q stays frozen during HOLD.
- Reset mid-operation: assert reset in GRANT cycle → next cycle q=0, q_valid=0, gnt=0, ptr=0. A subsequent req=4'b0010 is granted normally.
